// File: rtl/vcii_zout_meter.sv
`default_nettype none
// ============================================================================
// Module      : vcii_zout_meter
// Description : Density (sinc1) and rising-edge counter for the comparator
//               bitstream that slices the VCII z-node against ref. The raw
//               comparator bit is synchronised, then integrated over a
//               programmable window of 2^(win_sel+4) cycles. Results are
//               published with a one-cycle valid strobe.
// Ports       : clk, rst (async, active-high)
//               ena          - tile enable, low forces IDLE
//               cmp_in       - asynchronous comparator bit
//               start        - level; high in IDLE begins a measurement
//               cont         - re-arm automatically after each window
//               win_sel[3:0] - window code, clamped to WIN_MAX
//               ones_cnt     - synced-high cycles in last completed window
//               edge_cnt     - rising edges in last completed window
//               result_valid - one-cycle strobe when results update
//               busy         - high in any state other than IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module vcii_zout_meter #(
    parameter int CNT_W   = 16,
    parameter int WIN_MAX = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             cmp_in,
    input  logic             start,
    input  logic             cont,
    input  logic [3:0]       win_sel,
    output logic [CNT_W-1:0] ones_cnt,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             result_valid,
    output logic             busy
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_settle  = 2'd1;
    localparam logic [1:0] c_st_measure = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    // Window counter must hold W-1 for the largest window, 2^(WIN_MAX+4)-1.
    localparam int         c_wcnt_w  = WIN_MAX + 4;
    localparam logic [3:0] c_win_max = 4'(WIN_MAX);

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic                r_s1;
    logic                r_s2;
    logic                r_s3;
    logic                r_settle;
    logic [3:0]          r_win;
    logic [c_wcnt_w-1:0] r_wcnt;
    logic [CNT_W-1:0]    r_acc_ones;
    logic [CNT_W-1:0]    r_acc_edge;
    logic                r_valid;
    logic [CNT_W-1:0]    r_ones_cnt;
    logic [CNT_W-1:0]    r_edge_cnt;

    logic                w_rise;
    logic [3:0]          w_win_code;
    logic [3:0]          w_load_code;
    logic [c_wcnt_w-1:0] w_load;
    logic                w_enter_measure;
    logic                w_finish;

    assign w_rise     = r_s2 & ~r_s3;
    assign w_win_code = (win_sel > c_win_max) ? c_win_max : win_sel;

    // A back-to-back window re-latches win_sel in DONE, so the counter load
    // must use the freshly clamped code there rather than the stale latch.
    assign w_load_code = (r_state == c_st_done) ? w_win_code : r_win;
    assign w_load      = (c_wcnt_w'(1) << ({1'b0, w_load_code} + 5'd4)) - c_wcnt_w'(1);

    assign w_enter_measure = (w_next == c_st_measure) && (r_state != c_st_measure);
    assign w_finish        = (r_state == c_st_measure) && (w_next == c_st_done);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; ena low overrides every state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        if (!ena) begin
            w_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:    if (start) w_next = c_st_settle;
                c_st_settle:  if (r_settle) w_next = c_st_measure;
                c_st_measure: if (r_wcnt == '0) w_next = c_st_done;
                c_st_done:    w_next = cont ? c_st_measure : c_st_idle;
                default:      w_next = c_st_idle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Synchroniser, window counter, accumulators and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_settle   <= 1'b0;
            r_win      <= 4'd0;
            r_wcnt     <= '0;
            r_acc_ones <= '0;
            r_acc_edge <= '0;
            r_valid    <= 1'b0;
            r_ones_cnt <= '0;
            r_edge_cnt <= '0;
        end else begin
            r_s1 <= cmp_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            // Second SETTLE cycle is flagged by r_settle being set by the first.
            r_settle <= (r_state == c_st_settle);

            if ((r_state == c_st_idle && w_next == c_st_settle) || r_state == c_st_done) begin
                r_win <= w_win_code;
            end

            if (w_enter_measure) begin
                r_wcnt <= w_load;
            end else if (r_state == c_st_measure) begin
                r_wcnt <= r_wcnt - c_wcnt_w'(1);
            end

            // Accumulate only while staying in MEASURE; every other path
            // (window end, SETTLE, ena drop) leaves the accumulators clear.
            if (r_state == c_st_measure && w_next == c_st_measure) begin
                r_acc_ones <= r_acc_ones + CNT_W'(r_s2);
                r_acc_edge <= r_acc_edge + CNT_W'(w_rise);
            end else begin
                r_acc_ones <= '0;
                r_acc_edge <= '0;
            end

            // The last MEASURE sample is folded in directly so results and
            // strobe are both visible during the DONE cycle.
            r_valid <= w_finish;
            if (w_finish) begin
                r_ones_cnt <= r_acc_ones + CNT_W'(r_s2);
                r_edge_cnt <= r_acc_edge + CNT_W'(w_rise);
            end
        end
    end

    assign ones_cnt     = r_ones_cnt;
    assign edge_cnt     = r_edge_cnt;
    assign result_valid = r_valid;
    assign busy         = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_vcii_zout_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vcii_zout_meter
// Description : Self-checking bench for vcii_zout_meter. Every sampled
//               comparator bit is logged by edge number; expected counts are
//               sums over that log for the window implied by start timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vcii_zout_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        cmp_in;
    logic        start;
    logic        cont;
    logic [3:0]  win_sel;
    logic [15:0] ones_cnt;
    logic [15:0] edge_cnt;
    logic        result_valid;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // cmp_in value present at each rising edge, indexed by edge number
    bit hist [0:65535];
    int cyc  = 0;
    int mode = 0;

    int prev_ones = 0;
    int prev_edge = 0;

    vcii_zout_meter #(.CNT_W(16), .WIN_MAX(11)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .cmp_in       (cmp_in),
        .start        (start),
        .cont         (cont),
        .win_sel      (win_sel),
        .ones_cnt     (ones_cnt),
        .edge_cnt     (edge_cnt),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cyc < 65536) hist[cyc] <= cmp_in;
        cyc <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int win_len(input int ws);
        return 1 << (((ws > 11) ? 11 : ws) + 4);
    endfunction

    // Counted bit at accumulate edge e is the comparator two edges earlier.
    function automatic int model_ones(input int a, input int w);
        int s = 0;
        for (int e = a; e < a + w; e++) s += int'(hist[e-2]);
        return s;
    endfunction

    function automatic int model_edges(input int a, input int w);
        int s = 0;
        for (int e = a; e < a + w; e++) s += int'(hist[e-2] & ~hist[e-3]);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        case (mode)
            0:       cmp_in = 1'b0;
            1:       cmp_in = 1'b1;
            2:       cmp_in = ((cyc >> 2) & 1) != 0;
            3:       cmp_in = (cyc % 4) == 0;
            default: cmp_in = ($urandom_range(0, 1) == 1);
        endcase
    endtask

    task automatic start_window(input int ws, output int s);
        win_sel = 4'(ws);
        start   = 1'b1;
        s       = cyc;
        tick();
        start   = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_valid(input int budget, output int ve);
        ve = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (result_valid === 1'b1) begin
                ve = cyc - 1;
                break;
            end
        end
        chk("strobe_seen", int'(ve >= 0), 1);
    endtask

    // Checks strobe edge and counts for a window whose first accumulate
    // edge is a, then verifies the strobe drops on the following cycle.
    task automatic check_window(input string tag, input int a, input int w,
                                input int ve_exp, input int ve);
        int eo;
        int ee;
        eo = model_ones(a, w);
        ee = model_edges(a, w);
        chk({tag, "_strobe_edge"}, ve, ve_exp);
        chk({tag, "_ones"}, int'(ones_cnt), eo);
        chk({tag, "_edges"}, int'(edge_cnt), ee);
        prev_ones = eo;
        prev_edge = ee;
        tick();
        chk({tag, "_strobe_single"}, int'(result_valid), 0);
    endtask

    initial begin
        int s;
        int ve;
        int w;
        int pulses;

        rst = 1'b1; ena = 1'b1; cmp_in = 1'b0; start = 1'b0; cont = 1'b0; win_sel = 4'd0;
        repeat (3) tick();
        chk("rst_ones", int'(ones_cnt), 0);
        chk("rst_edges", int'(edge_cnt), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (3) tick();

        // Constant high, W=16
        mode = 1;
        repeat (5) tick();
        start_window(0, s);
        wait_valid(40, ve);
        check_window("const1", s + 3, 16, s + 18, ve);
        chk("const1_idle_after", int'(busy), 0);

        // Constant low
        mode = 0;
        repeat (5) tick();
        start_window(0, s);
        wait_valid(40, ve);
        check_window("const0", s + 3, 16, s + 18, ve);

        // Square wave, period 8, W=64
        mode = 2;
        start_window(2, s);
        wait_valid(100, ve);
        check_window("square", s + 3, 64, s + 2 + 64, ve);

        // Continuous mode, 25 % duty, W=32, period W+1
        mode = 3;
        cont = 1'b1;
        start_window(1, s);
        wait_valid(60, ve);
        check_window("cont0", s + 3, 32, s + 34, ve);
        for (int k = 1; k < 4; k++) begin
            int prev_ve;
            prev_ve = ve;
            wait_valid(60, ve);
            check_window("cont", prev_ve + 2, 32, prev_ve + 33, ve);
        end
        cont = 1'b0;
        begin
            int prev_ve;
            prev_ve = ve;
            wait_valid(60, ve);
            check_window("cont_last", prev_ve + 2, 32, prev_ve + 33, ve);
        end
        chk("cont_stop_busy", int'(busy), 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (result_valid === 1'b1) pulses++;
        end
        chk("cont_stop_no_pulse", pulses, 0);

        // Random bitstreams with random window codes
        mode = 4;
        for (int k = 0; k < 3; k++) begin
            int ws;
            ws = int'($urandom_range(0, 3));
            w  = win_len(ws);
            start_window(ws, s);
            wait_valid(w + 10, ve);
            check_window("random", s + 3, w, s + 2 + w, ve);
            repeat (2) tick();
        end

        // ena drop mid-window: no strobe, results held
        start_window(2, s);
        repeat (20) tick();
        ena = 1'b0;
        tick();
        chk("ena_drop_busy", int'(busy), 0);
        chk("ena_drop_valid", int'(result_valid), 0);
        chk("ena_drop_ones_held", int'(ones_cnt), prev_ones);
        chk("ena_drop_edges_held", int'(edge_cnt), prev_edge);
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (result_valid === 1'b1) pulses++;
        end
        chk("ena_drop_no_pulse", pulses, 0);
        ena = 1'b1;
        tick();

        // start while busy must not disturb window timing
        start_window(1, s);
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(60, ve);
        check_window("restart_busy", s + 3, 32, s + 34, ve);
        repeat (3) tick();

        // Asynchronous reset mid-window
        mode = 2;
        start_window(3, s);
        repeat (30) tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_ones", int'(ones_cnt), 0);
        chk("rst_mid_edges", int'(edge_cnt), 0);
        chk("rst_mid_valid", int'(result_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy === 1'b1) pulses++;
        end
        chk("rst_release_idle", pulses, 0);

        // Clamped maximum window, constant high
        mode = 1;
        repeat (5) tick();
        start_window(15, s);
        wait_valid(32768 + 20, ve);
        check_window("clamp_max", s + 3, 32768, s + 2 + 32768, ve);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
